// File: rtl/control_multi.sv
`default_nettype none
// ============================================================================
//  Module   : control_multi
//  Purpose  : Multi-cycle MIPS-subset main control FSM. Sequences one
//             instruction at a time through FETCH/DECODE and the class-specific
//             execute/memory/write-back states, stalling on memory accesses
//             until MemReady is seen.
//  Ports    : clk, rst (async, active-high)
//             opcode[5:0]  - IR[31:26], sampled in DECODE only
//             MemReady     - memory access completes this cycle
//             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//             MemtoReg, PCSource[1:0], ALUOp[1:0], ALUSrcA, ALUSrcB[1:0],
//             RegWrite, RegDst - datapath controls (Moore, except the
//             MemReady-qualified strobes noted below)
//             Done         - instruction retire pulse
//             IllegalOp    - unsupported opcode seen in DECODE
//             state[3:0]   - current state for debug
//  Revision : 1.0 - initial release
// ============================================================================
module control_multi (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       Done,
    output logic       IllegalOp,
    output logic [3:0] state
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMRD    = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWR    = 4'd5;
    localparam logic [3:0] c_EXEC     = 4'd6;
    localparam logic [3:0] c_RWB      = 4'd7;
    localparam logic [3:0] c_BRANCH   = 4'd8;
    localparam logic [3:0] c_JUMP     = 4'd9;
    localparam logic [3:0] c_ADDIU_EX = 4'd10;
    localparam logic [3:0] c_ADDIU_WB = 4'd11;

    localparam logic [5:0] c_OP_RTYPE = 6'd0;
    localparam logic [5:0] c_OP_J     = 6'd2;
    localparam logic [5:0] c_OP_BEQ   = 6'd4;
    localparam logic [5:0] c_OP_ADDIU = 6'd9;
    localparam logic [5:0] c_OP_LW    = 6'd35;
    localparam logic [5:0] c_OP_SW    = 6'd43;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [5:0] r_opcode;   // opcode captured in DECODE; later states use only this copy

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_FETCH;
            r_opcode <= 6'd0;
        end else begin
            r_state <= w_next;
            if (r_state == c_DECODE) begin
                r_opcode <= opcode;
            end
        end
    end

    assign state = r_state;

    // Next-state and output decode. Everything defaults to 0 so each state
    // only names what it asserts; the trailing rst override keeps the FETCH
    // strobes (notably MemRead) quiet while reset is held.
    always_comb begin
        w_next      = c_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        Done        = 1'b0;
        IllegalOp   = 1'b0;

        case (r_state)
            c_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
                w_next  = MemReady ? c_DECODE : c_FETCH;
            end
            c_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    c_OP_RTYPE:        w_next = c_EXEC;
                    c_OP_ADDIU:        w_next = c_ADDIU_EX;
                    c_OP_LW, c_OP_SW:  w_next = c_MEMADR;
                    c_OP_BEQ:          w_next = c_BRANCH;
                    c_OP_J:            w_next = c_JUMP;
                    default: begin
                        w_next    = c_FETCH;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            c_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (r_opcode == c_OP_LW) ? c_MEMRD : c_MEMWR;
            end
            c_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                w_next  = MemReady ? c_MEMWB : c_MEMRD;
            end
            c_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                Done     = 1'b1;
            end
            c_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Done     = MemReady;
                w_next   = MemReady ? c_FETCH : c_MEMWR;
            end
            c_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = c_RWB;
            end
            c_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                Done     = 1'b1;
            end
            c_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                Done        = 1'b1;
            end
            c_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                Done     = 1'b1;
            end
            c_ADDIU_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = c_ADDIU_WB;
            end
            c_ADDIU_WB: begin
                RegWrite = 1'b1;
                Done     = 1'b1;
            end
            default: begin
                w_next = c_FETCH;   // unused codes 12-15 recover to FETCH
            end
        endcase

        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            PCSource    = 2'b00;
            ALUOp       = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            Done        = 1'b0;
            IllegalOp   = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_multi
//  Purpose  : Self-checking bench for control_multi. An instruction-level
//             model turns (opcode, fetch wait, memory wait) into the expected
//             per-cycle state and control vector.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, Done, IllegalOp;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    control_multi dut (
        .clk(clk), .rst(rst), .opcode(opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .Done(Done), .IllegalOp(IllegalOp), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       m2r;
        logic [1:0] pcs;
        logic [1:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       rw;
        logic       rdst;
        logic       done;
        logic       ill;
        logic [3:0] st;
    } exp_t;

    typedef struct {
        logic       mrdy;
        logic [5:0] op;
        exp_t       e;
    } cyc_t;

    cyc_t q[$];

    function automatic exp_t observed();
        return exp_t'({PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                       MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
                       RegDst, Done, IllegalOp, state});
    endfunction

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(63, 0));
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    // Instruction-level reference: the cycle list an instruction should take
    // and what each cycle must assert, straight from the state descriptions.
    task automatic build(input logic [5:0] op, input int fw, input int mw);
        exp_t e;
        q.delete();
        e = blank(4'd0); e.mr = 1'b1; e.srcb = 2'b01;
        for (int i = 0; i < fw; i++) q.push_back('{1'b0, rnd6(), e});
        e.irw = 1'b1; e.pcw = 1'b1;
        q.push_back('{1'b1, rnd6(), e});
        e = blank(4'd1); e.srcb = 2'b11;
        e.ill = !(op inside {6'd0, 6'd2, 6'd4, 6'd9, 6'd35, 6'd43});
        q.push_back('{rnd1(), op, e});
        case (op)
            6'd35, 6'd43: begin
                e = blank(4'd2); e.srca = 1'b1; e.srcb = 2'b10;
                q.push_back('{rnd1(), rnd6(), e});
                if (op == 6'd35) begin
                    e = blank(4'd3); e.mr = 1'b1; e.iord = 1'b1;
                    for (int i = 0; i < mw; i++) q.push_back('{1'b0, rnd6(), e});
                    q.push_back('{1'b1, rnd6(), e});
                    e = blank(4'd4); e.rw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
                    q.push_back('{rnd1(), rnd6(), e});
                end else begin
                    e = blank(4'd5); e.mw = 1'b1; e.iord = 1'b1;
                    for (int i = 0; i < mw; i++) q.push_back('{1'b0, rnd6(), e});
                    e.done = 1'b1;
                    q.push_back('{1'b1, rnd6(), e});
                end
            end
            6'd0: begin
                e = blank(4'd6); e.srca = 1'b1; e.aluop = 2'b10;
                q.push_back('{rnd1(), rnd6(), e});
                e = blank(4'd7); e.rw = 1'b1; e.rdst = 1'b1; e.done = 1'b1;
                q.push_back('{rnd1(), rnd6(), e});
            end
            6'd4: begin
                e = blank(4'd8); e.srca = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1;
                e.pcs = 2'b01; e.done = 1'b1;
                q.push_back('{rnd1(), rnd6(), e});
            end
            6'd2: begin
                e = blank(4'd9); e.pcw = 1'b1; e.pcs = 2'b10; e.done = 1'b1;
                q.push_back('{rnd1(), rnd6(), e});
            end
            6'd9: begin
                e = blank(4'd10); e.srca = 1'b1; e.srcb = 2'b10;
                q.push_back('{rnd1(), rnd6(), e});
                e = blank(4'd11); e.rw = 1'b1; e.done = 1'b1;
                q.push_back('{rnd1(), rnd6(), e});
            end
            default: ;
        endcase
    endtask

    // Runs one instruction (or its first max_cyc cycles). Entered and left
    // 1 time unit after a rising edge.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input int max_cyc, input string name);
        exp_t obs;
        int   n;
        int   done_at;
        int   lat;
        build(op, fw, mw);
        n       = (max_cyc < q.size()) ? max_cyc : q.size();
        done_at = -1;
        for (int i = 0; i < n; i++) begin
            MemReady = q[i].mrdy;
            opcode   = q[i].op;
            @(negedge clk);
            obs = observed();
            n_tests++;
            if (obs !== q[i].e) begin
                n_fail++;
                $display("FAIL %s op=%0d cyc%0d: got %h want %h", name, op, i, obs, q[i].e);
            end
            n_tests++;
            if ((PCWrite & PCWriteCond) | (MemRead & MemWrite)) begin
                n_fail++;
                $display("FAIL %s excl cyc%0d: got pcw=%b pcwc=%b mr=%b mw=%b want no overlap",
                         name, i, PCWrite, PCWriteCond, MemRead, MemWrite);
            end
            if (done_at < 0 && Done === 1'b1) done_at = i + 1;
            @(posedge clk);
            #1;
        end
        if (n == q.size() && op inside {6'd0, 6'd2, 6'd4, 6'd9, 6'd35, 6'd43}) begin
            case (op)
                6'd35:        lat = 5 + fw + mw;
                6'd43:        lat = 4 + fw + mw;
                6'd0, 6'd9:   lat = 4 + fw;
                default:      lat = 3 + fw;
            endcase
            n_tests++;
            if (done_at != lat) begin
                n_fail++;
                $display("FAIL %s latency op=%0d: got %0d want %0d", name, op, done_at, lat);
            end
        end
    endtask

    task automatic test_reset();
        exp_t obs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            MemReady = 1'b1;
            opcode   = rnd6();
            @(negedge clk);
            obs = observed();
            n_tests++;
            if (obs !== blank(4'd0)) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h want %h", i, obs, blank(4'd0));
            end
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        MemReady = 1'b0;
    endtask

    task automatic test_lw();
        run_instr(6'd35, 0, 0, 1000, "lw");
        run_instr(6'd35, 2, 1, 1000, "lw_wait");
    endtask

    task automatic test_sw_wait();
        run_instr(6'd43, 0, 3, 1000, "sw_wait");
    endtask

    task automatic test_back_to_back();
        run_instr(6'd0, 0, 0, 1000, "b2b_r");
        run_instr(6'd4, 0, 0, 1000, "b2b_beq");
        run_instr(6'd9, 0, 0, 1000, "b2b_addiu");
    endtask

    task automatic test_jump();
        run_instr(6'd2, 0, 0, 1000, "jump");
    endtask

    task automatic test_illegal();
        run_instr(6'd63, 0, 0, 1000, "illegal");
        run_instr(6'd4, 0, 0, 1000, "after_illegal");
    endtask

    task automatic test_async_reset();
        exp_t obs;
        run_instr(6'd35, 0, 5, 4, "rd_wait");
        n_tests++;
        if (state !== 4'd3 || MemRead !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst: got state=%0d mr=%b want state=3 mr=1", state, MemRead);
        end
        #2;
        rst = 1'b1;
        #1;
        obs = observed();
        n_tests++;
        if (obs !== blank(4'd0)) begin
            n_fail++;
            $display("FAIL async_rst: got %h want %h", obs, blank(4'd0));
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        MemReady = 1'b0;
        run_instr(6'd0, 1, 0, 1000, "post_rst");
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        logic [5:0] op;
        ops = '{6'd0, 6'd2, 6'd4, 6'd9, 6'd35, 6'd43};
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(6, 0) == 6) op = rnd6();
            else                           op = ops[$urandom_range(5, 0)];
            run_instr(op, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), 1000, "rand");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        MemReady = 1'b0;
        opcode   = 6'd0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_back_to_back();
        test_jump();
        test_illegal();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_multi.md
CONTROL_MULTI -- requirements
Module: control_multi

Interface
REQ-001 The block SHALL have no parameters; the state encoding is fixed by REQ-021.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: opcode  input  6  instruction register bits [31:26]; sampled only in DECODE.
REQ-006 Port: MemReady  input  1  memory handshake; 1 = the current access completes this cycle.
REQ-007 Port: PCWrite  output  1  unconditional PC load.
REQ-008 Port: PCWriteCond  output  1  PC load qualified externally by ALU zero.
REQ-009 Port: IorD  output  1  memory address mux select (0 = PC, 1 = ALUOut).
REQ-010 Port: MemRead  output  1  memory read strobe.
REQ-011 Port: MemWrite  output  1  memory write strobe.
REQ-012 Port: IRWrite  output  1  instruction register load.
REQ-013 Port: MemtoReg  output  1  write-back mux select (1 = MDR).
REQ-014 Port: PCSource  output  2  PC mux select (00 = ALU, 01 = ALUOut, 10 = jump target).
REQ-015 Port: ALUOp  output  2  to ALU control (00 = add, 01 = sub, 10 = funct).
REQ-016 Port: ALUSrcA  output  1  ALU A select (0 = PC, 1 = rs).
REQ-017 Port: ALUSrcB  output  2  ALU B select (00 = rt, 01 = 4, 10 = signext imm, 11 = imm<<2).
REQ-018 Port: RegWrite  output  1  register file write enable.
REQ-019 Port: RegDst  output  1  write register select (1 = rd, 0 = rt).
REQ-020 Ports: Done  output  1  instruction-retire pulse; IllegalOp  output  1  unsupported-opcode pulse; state  output  4  current state, for debug.

Function
REQ-021 States SHALL be encoded as: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIU_EX 10, ADDIU_WB 11. Codes 12-15 SHALL go to FETCH on the next edge.
REQ-022 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
REQ-023 In FETCH, IRWrite and PCWrite SHALL equal MemReady. FETCH SHALL stay in FETCH while MemReady=0 and go to DECODE when MemReady=1.
REQ-024 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
- 0 -> EXEC
- 9 -> ADDIU_EX
- 35 or 43 -> MEMADR
- 4 -> BRANCH
- 2 -> JUMP
- any other opcode -> FETCH, with IllegalOp=1 for that cycle.
REQ-025 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00. It SHALL go to MEMRD if the latched opcode is 35, otherwise to MEMWR.
REQ-026 The opcode SHALL be latched internally at DECODE, so later changes on the opcode input do not affect sequencing.
REQ-027 MEMRD SHALL drive MemRead=1, IorD=1. It SHALL hold while MemReady=0 and go to MEMWB when MemReady=1.
REQ-028 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, Done=1, then go to FETCH.
REQ-029 MEMWR SHALL drive MemWrite=1, IorD=1. It SHALL hold while MemReady=0. When MemReady=1 it SHALL assert Done=1 and go to FETCH.
REQ-030 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to RWB.
REQ-031 RWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, Done=1, then go to FETCH.
REQ-032 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, Done=1, then go to FETCH.
REQ-033 JUMP SHALL drive PCWrite=1, PCSource=10, Done=1, then go to FETCH.
REQ-034 ADDIU_EX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIU_WB.
REQ-035 ADDIU_WB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, Done=1, then go to FETCH.
REQ-036 Every output not listed for a state SHALL be 0. No output SHALL ever be X.
REQ-037 With MemReady held at 1, latency from entering FETCH to the Done cycle inclusive SHALL be:
- LW 5
- SW 4
- R-type 4
- ADDIU 4
- BEQ 3
- J 3.
Each memory wait cycle SHALL add exactly one cycle.
REQ-038 PCWrite and PCWriteCond SHALL never both be 1. MemRead and MemWrite SHALL never both be 1.

Reset
REQ-039 While rst=1, state SHALL be FETCH and all outputs SHALL be 0, including MemRead; the FETCH decode SHALL be gated by rst.
REQ-040 Reset asserted in any state, including mid memory wait, SHALL abort the instruction immediately with no write-enable pulse.
REQ-041 After rst deasserts, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-042 The bench SHALL cover these directed scenarios:
- Reset, then MemReady=1 and opcode=35 -> states 0,1,2,3,4; RegWrite=1, MemtoReg=1 and Done=1 only in state 4.
- opcode=43 with MemReady=0 for 3 cycles in MEMWR -> MemWrite held high for 4 cycles; Done=1 only on the MemReady=1 cycle; then FETCH.
- opcode=0 then opcode=4 back-to-back -> states 0,1,6,7,0,1,8,0; ALUOp=10 in EXEC; PCWriteCond=1 and ALUOp=01 in BRANCH.
- opcode=2 -> PCWrite=1, PCSource=10 in JUMP; total 3 cycles.
- opcode=63 -> IllegalOp=1 in DECODE; returns to FETCH; no RegWrite, MemWrite or PCWrite pulse.
- rst asserted asynchronously mid-MEMRD wait -> state=0 and all outputs 0 without waiting for a clock edge.
REQ-043 The bench SHALL check the REQ-038 exclusions on every cycle of every scenario.
